// File: rtl/harris_detector.sv
// Streaming Harris corner detector: 3x3 Sobel, 3x3 box-summed structure tensor,
// R = det - (trace^2 >> K_SHIFT), one response per accepted pixel, 5-cycle latency.
module harris_detector #(
  parameter int                IMG_W   = 128,
  parameter int                IMG_H   = 128,
  parameter int                K_SHIFT = 4,
  parameter logic signed [43:0] THRESH = 44'sd1000000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          pixel,
  input  logic                pixel_valid,
  output logic                out_valid,
  output logic signed [43:0]  response,
  output logic                corner,
  output logic [15:0]         out_row,
  output logic [15:0]         out_col
);
  localparam int          AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] W_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0] H_LAST  = 16'(IMG_H - 1);
  localparam logic [15:0] W_M2    = 16'(IMG_W - 2);
  localparam logic [15:0] ROW_MAX = 16'(IMG_H - 3);
  localparam logic [15:0] COL_MAX = 16'(IMG_W - 3);

  typedef struct packed {
    logic        emit;
    logic        border;
    logic [15:0] row;
    logic [15:0] col;
  } tag_t;

  logic [15:0] col_q, col_d, row_q, row_d;
  logic [15:0] crow, ccol;
  logic [AW-1:0] addr;
  tag_t tag_d;
  tag_t tag_q [5];
  logic [AW-1:0] a_q [3];
  logic [4:0] v_q;

  assign addr = col_q[AW-1:0];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == W_LAST) begin
        col_d = '0;
        row_d = (row_q == H_LAST) ? '0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  // Centre completed by this pixel sits 2 lines + 2 pixels back, wrapping into the previous line.
  always_comb begin
    crow = row_q - 16'd2;
    ccol = col_q - 16'd2;
    if (col_q < 16'd2) begin
      crow = row_q - 16'd3;
      ccol = col_q + W_M2;
    end
    tag_d.emit   = (row_q > 16'd2) || ((row_q == 16'd2) && (col_q >= 16'd2));
    tag_d.border = (crow < 16'd2) || (crow > ROW_MAX) || (ccol < 16'd2) || (ccol > COL_MAX);
    tag_d.row    = crow;
    tag_d.col    = ccol;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      v_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v_q   <= {v_q[3:0], pixel_valid};
    end
  end

  // Stage A: pixel line buffers and 3x3 window ([row][col], row 2 / col 2 newest)
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] pw_q [3][3];
  logic signed [10:0] gx_raw, gy_raw;
  logic signed [8:0]  gx_q, gy_q;

  function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c);
    return signed'({3'b000, a}) + signed'({2'b00, b, 1'b0}) + signed'({3'b000, c});
  endfunction

  assign gx_raw = wsum(pw_q[0][2], pw_q[1][2], pw_q[2][2]) - wsum(pw_q[0][0], pw_q[1][0], pw_q[2][0]);
  assign gy_raw = wsum(pw_q[2][0], pw_q[2][1], pw_q[2][2]) - wsum(pw_q[0][0], pw_q[0][1], pw_q[0][2]);

  // Stage B/C: products, product line buffers, column sums
  logic signed [16:0] gx17, gy17;
  logic [15:0]        ixx_q, iyy_q;
  logic signed [16:0] ixy_q;
  logic [15:0]        pxx0 [IMG_W];
  logic [15:0]        pxx1 [IMG_W];
  logic [15:0]        pyy0 [IMG_W];
  logic [15:0]        pyy1 [IMG_W];
  logic signed [16:0] pxy0 [IMG_W];
  logic signed [16:0] pxy1 [IMG_W];
  logic [17:0]        csxx_q [3];
  logic [17:0]        csyy_q [3];
  logic signed [18:0] csxy_q [3];
  logic [19:0]        sxx_q, syy_q;
  logic signed [20:0] sxy_q;

  assign gx17 = 17'(gx_q);
  assign gy17 = 17'(gy_q);

  always_ff @(posedge clk) begin
    if (reset && pixel_valid) begin
      lb0[addr] <= pixel;
      lb1[addr] <= lb0[addr];
      for (int unsigned r = 0; r < 3; r++) begin
        pw_q[r][0] <= pw_q[r][1];
        pw_q[r][1] <= pw_q[r][2];
      end
      pw_q[0][2] <= lb1[addr];
      pw_q[1][2] <= lb0[addr];
      pw_q[2][2] <= pixel;
    end
    tag_q[0] <= tag_d;
    for (int unsigned i = 1; i < 5; i++) tag_q[i] <= tag_q[i-1];
    a_q[0] <= addr;
    a_q[1] <= a_q[0];
    a_q[2] <= a_q[1];
    gx_q  <= 9'(gx_raw >>> 2);
    gy_q  <= 9'(gy_raw >>> 2);
    ixx_q <= 16'(gx17 * gx17);
    iyy_q <= 16'(gy17 * gy17);
    ixy_q <= gx17 * gy17;
    if (v_q[2]) begin
      pxx0[a_q[2]] <= ixx_q;
      pxx1[a_q[2]] <= pxx0[a_q[2]];
      pyy0[a_q[2]] <= iyy_q;
      pyy1[a_q[2]] <= pyy0[a_q[2]];
      pxy0[a_q[2]] <= ixy_q;
      pxy1[a_q[2]] <= pxy0[a_q[2]];
      for (int unsigned i = 0; i < 2; i++) begin
        csxx_q[i] <= csxx_q[i+1];
        csyy_q[i] <= csyy_q[i+1];
        csxy_q[i] <= csxy_q[i+1];
      end
      csxx_q[2] <= 18'(ixx_q) + 18'(pxx0[a_q[2]]) + 18'(pxx1[a_q[2]]);
      csyy_q[2] <= 18'(iyy_q) + 18'(pyy0[a_q[2]]) + 18'(pyy1[a_q[2]]);
      csxy_q[2] <= 19'(ixy_q) + 19'(pxy0[a_q[2]]) + 19'(pxy1[a_q[2]]);
    end
    sxx_q <= 20'(csxx_q[0]) + 20'(csxx_q[1]) + 20'(csxx_q[2]);
    syy_q <= 20'(csyy_q[0]) + 20'(csyy_q[1]) + 20'(csyy_q[2]);
    sxy_q <= 21'(csxy_q[0]) + 21'(csxy_q[1]) + 21'(csxy_q[2]);
  end

  // Stage D: 44 bits hold every intermediate for 8-bit input
  logic signed [43:0] xx_e, yy_e, xy_e, tr, det, r_val;
  assign xx_e  = 44'(sxx_q);
  assign yy_e  = 44'(syy_q);
  assign xy_e  = 44'(sxy_q);
  assign tr    = xx_e + yy_e;
  assign det   = xx_e * yy_e - xy_e * xy_e;
  assign r_val = det - ((tr * tr) >>> K_SHIFT);

  logic               out_valid_q, corner_q;
  logic signed [43:0] response_q;
  logic [15:0]        out_row_q, out_col_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      response_q  <= '0;
      corner_q    <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= v_q[4] && tag_q[4].emit;
      if (v_q[4] && tag_q[4].emit) begin
        response_q <= tag_q[4].border ? '0 : r_val;
        corner_q   <= !tag_q[4].border && (r_val > THRESH);
        out_row_q  <= tag_q[4].row;
        out_col_q  <= tag_q[4].col;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign response  = response_q;
  assign corner    = corner_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
endmodule

// File: tb/tb_harris_detector.sv
// Directed bench for harris_detector on 8x8 frames with THRESH=0.
module tb_harris_detector;
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         pixel = '0;
  logic               pixel_valid = 1'b0;
  logic               out_valid;
  logic signed [43:0] response;
  logic               corner;
  logic [15:0]        out_row, out_col;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  harris_detector #(.IMG_W(8), .IMG_H(8), .K_SHIFT(4), .THRESH(44'sd0)) dut (
    .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid),
    .out_valid(out_valid), .response(response), .corner(corner),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     row;
    int     col;
    longint resp;
    bit     crn;
    longint cyc;
  } out_t;

  out_t   outs[$];
  longint accs[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      out_t o;
      o.row  = int'(out_row);
      o.col  = int'(out_col);
      o.resp = longint'(response);
      o.crn  = corner;
      o.cyc  = cyc;
      outs.push_back(o);
    end
  end

  // kind: 0 flat 100, 1 square at (>=4,>=4), 2 vertical edge at col>=4
  function automatic int pv(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (r >= 4 && c >= 4) ? 255 : 0;
      default: return (c >= 4) ? 255 : 0;
    endcase
  endfunction

  function automatic bit is_border(input int r, input int c);
    return (r < 2) || (r > 5) || (c < 2) || (c > 5);
  endfunction

  // Direct Harris evaluation on the whole frame (no streaming structure)
  function automatic longint exp_resp(input int kind, input int cr, input int cc);
    longint sxx = 0, syy = 0, sxy = 0, det, tr;
    if (is_border(cr, cc)) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int gr = cr + dr;
        int gc = cc + dc;
        int gx = (pv(kind, gr-1, gc+1) + 2*pv(kind, gr, gc+1) + pv(kind, gr+1, gc+1))
               - (pv(kind, gr-1, gc-1) + 2*pv(kind, gr, gc-1) + pv(kind, gr+1, gc-1));
        int gy = (pv(kind, gr+1, gc-1) + 2*pv(kind, gr+1, gc) + pv(kind, gr+1, gc+1))
               - (pv(kind, gr-1, gc-1) + 2*pv(kind, gr-1, gc) + pv(kind, gr-1, gc+1));
        gx = gx >>> 2;
        gy = gy >>> 2;
        sxx += longint'(gx * gx);
        syy += longint'(gy * gy);
        sxy += longint'(gx * gy);
      end
    det = sxx * syy - sxy * sxy;
    tr  = sxx + syy;
    return det - ((tr * tr) >>> 4);
  endfunction

  function automatic bit exp_corner(input int kind, input int r, input int c);
    return !is_border(r, c) && (exp_resp(kind, r, c) > 0);
  endfunction

  task automatic put_pixel(input int v);
    @(negedge clk);
    pixel       = 8'(v);
    pixel_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      put_pixel(pv(kind, i / 8, i % 8));
      if (i >= 18) accs.push_back(cyc + 1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || response !== 44'sd0 || corner !== 1'b0 || out_row !== 16'd0 || out_col !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%0d c=%b row=%0d col=%0d required all zero",
               out_valid, response, corner, out_row, out_col);
    end
    reset = 1'b1;
  endtask

  task automatic test_frame(input string name, input int kind, input bit gaps);
    outs.delete();
    accs.delete();
    send_frame(kind, gaps, 64);
    idle(10);
    n_checks++;
    if (outs.size() != 46) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required 46", name, outs.size());
    end
    for (int i = 0; i < outs.size(); i++) begin
      int r = i / 8;
      int c = i % 8;
      n_checks++;
      if (outs[i].row !== r || outs[i].col !== c) begin
        n_fail++;
        $display("FAIL %s_pos[%0d]: got (%0d,%0d) required (%0d,%0d)", name, i, outs[i].row, outs[i].col, r, c);
      end
      n_checks++;
      if (outs[i].resp !== exp_resp(kind, r, c) || outs[i].crn !== exp_corner(kind, r, c)) begin
        n_fail++;
        $display("FAIL %s_resp(%0d,%0d): got %0d/%b required %0d/%b", name, r, c,
                 outs[i].resp, outs[i].crn, exp_resp(kind, r, c), exp_corner(kind, r, c));
      end
      if (i < accs.size()) begin
        n_checks++;
        if (outs[i].cyc !== accs[i] + 5) begin
          n_fail++;
          $display("FAIL %s_latency[%0d]: got %0d cycles required 5", name, i, outs[i].cyc - accs[i]);
        end
      end
    end
  endtask

  task automatic test_flat;
    test_frame("flat", 0, 1'b0);
    for (int i = 0; i < outs.size(); i++) begin
      n_checks++;
      if (outs[i].resp !== 0 || outs[i].crn !== 1'b0) begin
        n_fail++;
        $display("FAIL flat_zero[%0d]: got %0d/%b required 0/0", i, outs[i].resp, outs[i].crn);
      end
    end
  endtask

  task automatic test_square;
    int     idx[3] = '{18, 36, 45};
    longint er[3]  = '{-64'sd3938240, 64'sd29212612619, 64'sd19468567110};
    bit     ec[3]  = '{1'b0, 1'b1, 1'b1};
    test_frame("square", 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (idx[k] < outs.size()) begin
        n_checks++;
        if (outs[idx[k]].resp !== er[k] || outs[idx[k]].crn !== ec[k]) begin
          n_fail++;
          $display("FAIL square_hand[%0d]: got %0d/%b required %0d/%b", idx[k],
                   outs[idx[k]].resp, outs[idx[k]].crn, er[k], ec[k]);
        end
      end
    end
  endtask

  task automatic test_vedge;
    longint ecol[4] = '{-64'sd2378390976, -64'sd9513563906, -64'sd9513563906, -64'sd2378390976};
    test_frame("vedge", 2, 1'b0);
    for (int i = 0; i < outs.size(); i++) begin
      int r = i / 8;
      int c = i % 8;
      longint e = is_border(r, c) ? 64'sd0 : ecol[c-2];
      n_checks++;
      if (outs[i].resp !== e || outs[i].crn !== 1'b0) begin
        n_fail++;
        $display("FAIL vedge_hand(%0d,%0d): got %0d/%b required %0d/0", r, c, outs[i].resp, outs[i].crn, e);
      end
    end
  endtask

  task automatic test_gaps;
    test_frame("gaps", 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    outs.delete();
    accs.delete();
    send_frame(2, 1'b0, 30);
    @(negedge clk);
    pixel_valid = 1'b0;
    reset       = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_row !== 16'd0 || out_col !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%b row=%0d col=%0d required 0/0/0", out_valid, out_row, out_col);
    end
    reset = 1'b1;
    test_frame("midreset", 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    outs.delete();
    accs.delete();
    send_frame(1, 1'b0, 64);
    send_frame(1, 1'b0, 64);
    idle(10);
    n_checks++;
    if (outs.size() != 92) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d required 92", outs.size());
    end
    for (int i = 0; i < outs.size(); i++) begin
      int r = (i % 46) / 8;
      int c = (i % 46) % 8;
      n_checks++;
      if (outs[i].row !== r || outs[i].col !== c ||
          outs[i].resp !== exp_resp(1, r, c) || outs[i].crn !== exp_corner(1, r, c)) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got (%0d,%0d) %0d/%b required (%0d,%0d) %0d/%b", i,
                 outs[i].row, outs[i].col, outs[i].resp, outs[i].crn, r, c,
                 exp_resp(1, r, c), exp_corner(1, r, c));
      end
      if (i < accs.size()) begin
        n_checks++;
        if (outs[i].cyc !== accs[i] + 5) begin
          n_fail++;
          $display("FAIL b2b_latency[%0d]: got %0d cycles required 5", i, outs[i].cyc - accs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_square();
    test_vedge();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
